hamming_secded_pipe: RTL

- Parametrised, pipelined SECDED decoder for extended Hamming codewords: 2^R-1 Hamming bits plus one overall parity bit.
- Generalises the fixed (15,11) single-error corrector:
  - any R;
  - double-error detection;
  - valid/ready streaming with backpressure;
  - error flags and position per word;
  - optional error counters.
- Sits between the channel/receive buffer and the data consumer.

---
 rtl/hamming_pkg.sv | 33 +++
 rtl/hamming_syndrome.sv | 22 ++
 rtl/hamming_secded_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared types and position-map helpers for the extended-Hamming SECDED decoder.
package hamming_pkg;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_PARITY = 2'd2,
    ERR_DOUBLE = 2'd3
  } err_class_e;

  function automatic int calc_n(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int calc_k(input int r);
    return calc_n(r) - r;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic int data_index(input int pos);
    int n_pow2;
    n_pow2 = 0;
    for (int j = 0; j < 31; j++) begin
      if ((1 << j) <= pos) n_pow2++;
    end
    return pos - 1 - n_pow2;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall parity of an extended Hamming word.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int R = 4
) (
  input  logic [(2**R)-1:0] i_word,
  output logic [R-1:0]      o_syndrome,
  output logic              o_parity
);

  localparam int N = calc_n(R);

  always_comb begin
    o_syndrome = '0;
    for (int i = 0; i < N; i++) begin
      if (i_word[i]) o_syndrome = o_syndrome ^ R'(i + 1);
    end
    o_parity = ^i_word;
  end

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready streaming.
// Optional saturating error counters are built when HAMMING_SECDED_PIPE_ERR_CNT_EN is defined.
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int R = 4
`ifdef HAMMING_SECDED_PIPE_ERR_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [(2**R)-1:0]    entrada,
  input  logic                 entrada_valid,
  output logic                 entrada_ready,
  output logic [(2**R)-R-2:0]  saida,
  output logic                 saida_valid,
  input  logic                 saida_ready,
  output logic                 erro_simples,
  output logic                 erro_duplo,
  output logic [R-1:0]         erro_pos
`ifdef HAMMING_SECDED_PIPE_ERR_CNT_EN
  , output logic [CNT_W-1:0]   cnt_simples,
  output logic [CNT_W-1:0]     cnt_duplo,
  input  logic                 cnt_clr
`endif
);

  localparam int N = calc_n(R);
  localparam int K = calc_k(R);

  logic         w_en;
  logic [R-1:0] w_syn;
  logic         w_par;

  logic         r_s1_valid;
  logic [N-1:0] r_s1_word;
  logic [R-1:0] r_s1_syn;
  logic         r_s1_par;

  logic         r_s2_valid;
  logic [K-1:0] r_saida;
  logic         r_simples;
  logic         r_duplo;
  logic [R-1:0] r_pos;

  err_class_e   w_class;
  logic [N-1:0] w_corr;
  logic [K-1:0] w_data;

  // Whole pipeline advances together; ready never looks at entrada_valid.
  assign w_en          = !r_s2_valid || saida_ready;
  assign entrada_ready = w_en;

  hamming_syndrome #(.R(R)) u_syndrome (
    .i_word     (entrada),
    .o_syndrome (w_syn),
    .o_parity   (w_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= entrada_valid;
      r_s1_word  <= entrada[N-1:0];
      r_s1_syn   <= w_syn;
      r_s1_par   <= w_par;
    end
  end

  always_comb begin
    w_class = ERR_NONE;
    if (r_s1_syn != '0) w_class = r_s1_par ? ERR_SINGLE : ERR_DOUBLE;
    else if (r_s1_par)  w_class = ERR_PARITY;

    w_corr = r_s1_word;
    for (int i = 0; i < N; i++) begin
      if (w_class == ERR_SINGLE && r_s1_syn == R'(i + 1)) w_corr[i] = ~r_s1_word[i];
    end

    w_data = '0;
    for (int pos = 1; pos <= N; pos++) begin
      if (!is_pow2(pos)) w_data[data_index(pos)] = w_corr[pos-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_saida    <= '0;
      r_simples  <= 1'b0;
      r_duplo    <= 1'b0;
      r_pos      <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_saida    <= w_data;
      r_simples  <= (w_class == ERR_SINGLE) || (w_class == ERR_PARITY);
      r_duplo    <= (w_class == ERR_DOUBLE);
      r_pos      <= r_s1_syn;
    end
  end

  assign saida        = r_saida;
  assign saida_valid  = r_s2_valid;
  assign erro_simples = r_simples;
  assign erro_duplo   = r_duplo;
  assign erro_pos     = r_pos;

`ifdef HAMMING_SECDED_PIPE_ERR_CNT_EN
  logic             w_hs;
  logic [CNT_W-1:0] r_cnt_simples;
  logic [CNT_W-1:0] r_cnt_duplo;

  assign w_hs = r_s2_valid && saida_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_simples <= '0;
      r_cnt_duplo   <= '0;
    end else if (cnt_clr) begin
      r_cnt_simples <= '0;
      r_cnt_duplo   <= '0;
    end else if (w_hs) begin
      if (r_simples && r_cnt_simples != '1) r_cnt_simples <= r_cnt_simples + 1'b1;
      if (r_duplo && r_cnt_duplo != '1)     r_cnt_duplo   <= r_cnt_duplo + 1'b1;
    end
  end

  assign cnt_simples = r_cnt_simples;
  assign cnt_duplo   = r_cnt_duplo;
`endif

endmodule
